// File: rtl/log_pkg.sv
// log_pkg
//   Shared definitions for the debug-log RAM sequencer: log data selector
//   codes, controller state encoding and the coefficient burst length.
package log_pkg;

    // Log data selector codes (i_data_selec_for_log)
    localparam int SEL_FSE   = 0;
    localparam int SEL_SLCR  = 1;
    localparam int SEL_COEFF = 2;
    localparam int SEL_ERR   = 3;

    // 176-bit coefficient sample (88 b I + 88 b Q) split into 32-bit words
    localparam int COEFF_WORDS = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } log_state_e;

endpackage

// File: rtl/coeff_burst_cnt.sv
// coeff_burst_cnt
//   Word counter for one coefficient burst. A start pulse opens a window of
//   WORDS cycles in which act_o is high and idx_o steps 0..WORDS-1.
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     start_i        launch a burst (ignored by the caller while act_o is high)
//     act_o          a burst word is presented this cycle
//     more_o         the burst still has words after the current one
//     idx_o          word index of the current burst word (0 when idle)
module coeff_burst_cnt
    import log_pkg::*;
#(
    parameter int WORDS = COEFF_WORDS
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       act_o,
    output logic       more_o,
    output logic [2:0] idx_o
);

    localparam logic [2:0] LAST = 3'(WORDS - 1);

    logic       act_q, act_d;
    logic [2:0] idx_q, idx_d;

    always_comb begin
        act_d = act_q;
        idx_d = idx_q;
        if (start_i) begin
            act_d = 1'b1;
            idx_d = 3'd0;
        end else if (act_q) begin
            if (idx_q == LAST) begin
                act_d = 1'b0;
                idx_d = 3'd0;   // idle index reads as 0 on the data mux select
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q <= 1'b0;
            idx_q <= 3'd0;
        end else begin
            act_q <= act_d;
            idx_q <= idx_d;
        end
    end

    assign act_o  = act_q;
    assign more_o = act_q && (idx_q != LAST);
    assign idx_o  = idx_q;

endmodule

// File: rtl/log_ram_sequencer.sv
// log_ram_sequencer
//   Arms, captures and closes a debug data log in the logging RAM, and serves
//   register-file reads of the RAM while no capture is running.
//   Ports:
//     i_clock, i_reset          clock, async active-low reset
//     i_start, i_stop           arm / abort pulses from the register file
//     i_data_selec_for_log      log source, sampled on i_start
//     i_enbl_rate_two/_one      BR*2 / BR sample strobes
//     i_rd_req, i_rd_adrs       read request (level) and address
//     o_wr_en, o_wr_adrs        RAM write port
//     o_word_sel                coefficient word slice for the data mux
//     o_sel_latched             selector held for the capture
//     o_rd_en, o_rd_adrs        RAM read port; o_rd_valid one cycle later
//     o_busy, o_done            capture running / closed (sticky)
//     o_overrun                 sticky: coefficient strobe dropped
//     o_sel_err                 pulse: invalid selector on i_start
//     o_word_count              words written in the last/current capture
module log_ram_sequencer
    import log_pkg::*;
#(
    parameter int NB_ADDR     = 15,
    parameter int NB_SEL      = 3,
    parameter int COEFF_WORDS = log_pkg::COEFF_WORDS
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [NB_SEL-1:0]  i_data_selec_for_log,
    input  logic               i_enbl_rate_two,
    input  logic               i_enbl_rate_one,
    input  logic               i_rd_req,
    input  logic [NB_ADDR-1:0] i_rd_adrs,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_adrs,
    output logic [2:0]         o_word_sel,
    output logic [NB_SEL-1:0]  o_sel_latched,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_adrs,
    output logic               o_rd_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun,
    output logic               o_sel_err,
    output logic [NB_ADDR:0]   o_word_count
);

    localparam logic [NB_ADDR:0] DEPTH = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_ADDR:0] LAST  = {1'b0, {NB_ADDR{1'b1}}};
    localparam logic [NB_ADDR:0] ONE   = 1;
    localparam logic [NB_ADDR:0] CW    = COEFF_WORDS[NB_ADDR:0];

    log_state_e         state_q;
    logic [NB_ADDR:0]   cnt_q;          // next write address == words written
    logic [NB_ADDR-1:0] wr_adrs_q, rd_adrs_q;
    logic [NB_SEL-1:0]  sel_q;
    logic               wr_en_q, rd_en_q, rd_valid_q, ovr_q, sel_err_q, stop_pend_q;

    logic       capturing, is_coeff, strobe, room_ok, launch, issue;
    logic       b_act, b_more;
    logic [2:0] b_idx;

    assign capturing = (state_q == ST_CAPTURE);
    assign is_coeff  = (sel_q == NB_SEL'(SEL_COEFF));
    assign room_ok   = (DEPTH - cnt_q) >= CW;

    always_comb begin
        strobe = i_enbl_rate_one;
        if (sel_q == NB_SEL'(SEL_FSE) || sel_q == NB_SEL'(SEL_SLCR))
            strobe = i_enbl_rate_two;
    end

    // A stop arriving with a coefficient strobe wins: no new burst is opened.
    assign launch = capturing && is_coeff && strobe && !b_act && room_ok
                    && !i_stop && !stop_pend_q;
    // One RAM word goes out on the edge after issue is high.
    assign issue  = capturing && (is_coeff ? (launch || b_more) : strobe);

    coeff_burst_cnt #(
        .WORDS (COEFF_WORDS)
    ) u_burst (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .start_i (launch),
        .act_o   (b_act),
        .more_o  (b_more),
        .idx_o   (b_idx)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_adrs_q   <= '0;
            rd_adrs_q   <= '0;
            sel_q       <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            ovr_q       <= 1'b0;
            sel_err_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            wr_en_q    <= issue;
            sel_err_q  <= 1'b0;
            rd_en_q    <= i_rd_req && !capturing;
            rd_adrs_q  <= i_rd_adrs;
            rd_valid_q <= rd_en_q;
            if (issue) begin
                wr_adrs_q <= cnt_q[NB_ADDR-1:0];
                cnt_q     <= cnt_q + ONE;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        if (i_data_selec_for_log <= NB_SEL'(SEL_ERR)) begin
                            state_q     <= ST_CAPTURE;
                            cnt_q       <= '0;
                            ovr_q       <= 1'b0;
                            stop_pend_q <= 1'b0;
                            sel_q       <= i_data_selec_for_log;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (is_coeff && strobe && b_act)
                        ovr_q <= 1'b1;
                    if (issue && cnt_q == LAST) begin
                        state_q <= ST_DONE;         // last RAM location written
                    end else if (is_coeff) begin
                        if (strobe && !b_act && !room_ok && !i_stop)
                            state_q <= ST_DONE;     // a burst would not fit
                        else if (i_stop || stop_pend_q) begin
                            // let the running burst drain before closing
                            if (b_more) stop_pend_q <= 1'b1;
                            else        state_q     <= ST_DONE;
                        end
                    end else if (i_stop) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_adrs     = wr_adrs_q;
    assign o_word_sel    = b_idx;
    assign o_sel_latched = sel_q;
    assign o_rd_en       = rd_en_q;
    assign o_rd_adrs     = rd_adrs_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_busy        = (state_q == ST_CAPTURE);
    assign o_done        = (state_q == ST_DONE);
    assign o_overrun     = ovr_q;
    assign o_sel_err     = sel_err_q;
    assign o_word_count  = cnt_q;

endmodule
